serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes diff = a - b, LSB first, one bit per clock. It has a single registered full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the team's full-adder datapath, and a start/busy/done handshake connects it to a controller. The result and final borrow are held until the next accepted start.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 30 +++
 rtl/half_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 86 ++++++++
 tb/tb_serial_subtractor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor x - y - b_in, built from two half subtractors like the FA/HA pair.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x    (x),
    .y    (y),
    .diff (d1),
    .b_out(b1)
  );

  half_subtractor u_hs1 (
    .x    (d1),
    .y    (b_in),
    .diff (diff),
    .b_out(b2)
  );

  assign b_out = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: x - y giving a difference bit and a borrow-out.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic b_out
);

  assign diff  = x ^ y;
  assign b_out = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with a start/busy/done handshake.
// diff and borrow are held from done until the next accepted start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  sa;
  logic [WIDTH-1:0]  sb;
  logic              bin;
  logic [CW-1:0]     count;
  logic              d;
  logic              bout;
  logic              accept;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .b_in (bin),
    .diff (d),
    .b_out(bout)
  );

  // A new request is only taken when no operation is in flight.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      bin    <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state  <= S_RUN;
        sa     <= a;
        sb     <= b;
        bin    <= 1'b0;
        count  <= '0;
        diff   <= '0;
        borrow <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            diff  <= {d, diff[WIDTH-1:1]};
            bin   <= bout;
            count <= count + 1'b1;
            if (count == LAST) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              borrow <= bout;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8) plus a WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .borrow(borrow4)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then scramble a/b; lat is the cycle (after accept) where done is seen.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_cnt);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start    = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
      tick();
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int pulses;
    int n;
    logic [7:0] got_diff;
    logic       got_borrow;

    vecs[0] = '{"sub_9_3",     8'd9,    8'd3,    8'h06, 1'b0};
    vecs[1] = '{"sub_3_9",     8'd3,    8'd9,    8'hFA, 1'b1};
    vecs[2] = '{"sub_0_ff",    8'h00,   8'hFF,   8'h01, 1'b1};
    vecs[3] = '{"sub_a5_a5",   8'hA5,   8'hA5,   8'h00, 1'b0};
    vecs[4] = '{"sub_200_100", 8'd200,  8'd100,  8'd100, 1'b0};
    vecs[5] = '{"sub_80_01",   8'h80,   8'h01,   8'h7F, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_diff", {24'b0, diff}, 0);
    check("reset_borrow", {31'b0, borrow}, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      do_op8(vecs[k].a, vecs[k].b, lat, bcnt);
      check({vecs[k].name, "_latency"}, lat, 9);
      check({vecs[k].name, "_busy_cycles"}, bcnt, 8);
      check({vecs[k].name, "_diff"}, {24'b0, diff}, {24'b0, vecs[k].diff});
      check({vecs[k].name, "_borrow"}, {31'b0, borrow}, {31'b0, vecs[k].borrow});
      tick();
      check({vecs[k].name, "_done_one_cycle"}, {31'b0, done}, 0);
      check({vecs[k].name, "_diff_held"}, {24'b0, diff}, {24'b0, vecs[k].diff});
    end

    // Second start mid-RUN must be ignored.
    a     = 8'd200;
    b     = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    tick();
    start      = 1'b0;
    pulses     = 0;
    got_diff   = '0;
    got_borrow = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        got_diff   = diff;
        got_borrow = borrow;
      end
      tick();
    end
    check("midrun_start_pulses", pulses, 1);
    check("midrun_start_diff", {24'b0, got_diff}, 100);
    check("midrun_start_borrow", {31'b0, got_borrow}, 0);

    // Back-to-back: start held high through DONE.
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    tick();
    a   = 8'h80;
    b   = 8'h01;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      tick();
    end
    check("b2b_first_latency", lat, 9);
    check("b2b_first_diff", {24'b0, diff}, 8'h0F);
    n = 1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    check("b2b_accept_busy", {31'b0, busy}, 1);
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("b2b_done_spacing", n, 9);
    check("b2b_second_diff", {24'b0, diff}, 8'h7F);
    check("b2b_second_borrow", {31'b0, borrow}, 0);
    tick();
    tick();

    // Asynchronous reset in RUN cycle 4 aborts without a done pulse.
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("partial_shift_diff", {24'b0, diff}, 8'hE0);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_diff", {24'b0, diff}, 0);
    check("abort_borrow", {31'b0, borrow}, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort_no_done", pulses, 0);
    do_op8(8'd5, 8'd7, lat, bcnt);
    check("after_abort_latency", lat, 9);
    check("after_abort_diff", {24'b0, diff}, 8'hFE);
    check("after_abort_borrow", {31'b0, borrow}, 1);
    tick();

    // Exhaustive sweep of the 4-bit instance against (a-b) mod 16 and a<b.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a4     = 4'(ai);
        b4     = 4'(bi);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        lat    = 0;
        for (int i = 1; i <= 12; i++) begin
          if (done4) begin
            lat = i;
            break;
          end
          tick();
        end
        check($sformatf("w4_latency_%0d_%0d", ai, bi), lat, 5);
        check($sformatf("w4_result_%0d_%0d", ai, bi), {27'b0, borrow4, diff4},
              {27'b0, (ai < bi) ? 1'b1 : 1'b0, 4'(ai - bi)});
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
